// File: rtl/intto_fp_pkg.sv
// Shared types and constants for the integer-to-float converter.
// The optional exception-flag output is enabled with INTTOFP_EXC_FLAGS_EN.
package intto_fp_pkg;

  typedef enum logic [1:0] {
    MODE_I16_F16 = 2'b00,
    MODE_I16_F32 = 2'b01,
    MODE_I32_F16 = 2'b10,
    MODE_I32_F32 = 2'b11
  } mode_e;

  localparam int FP32_BIAS   = 127;
  localparam int FP32_MANT_W = 23;
  localparam int FP32_EXP_W  = 8;
  localparam int FP16_BIAS   = 15;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_EXP_W  = 5;

  localparam logic [15:0] FP16_POS_INF = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF = 16'hFC00;

  typedef struct packed {
    logic        sign;
    logic [31:0] mag;
    logic [5:0]  lzc;
  } lane_s1_t;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Magnitude stays 32 bits wide so the most negative INT32 maps to 2^31.
  function automatic lane_s1_t lane_prep(input logic [31:0] x);
    lane_s1_t l;
    l.sign = x[31];
    l.mag  = x[31] ? (~x + 32'd1) : x;
    l.lzc  = clz32(l.mag);
    return l;
  endfunction

endpackage

// File: rtl/intto_fp_lane.sv
// One conversion lane: normalize, round-to-nearest-even and pack to FP32 or FP16.
// Overflow/inexact outputs exist only when INTTOFP_EXC_FLAGS_EN is defined.
module intto_fp_lane
  import intto_fp_pkg::*;
#(
  parameter bit HAS_FP32 = 1'b1
) (
  input  lane_s1_t    i_lane,
  input  logic        i_fp32,
  output logic [31:0] o_res
`ifdef INTTOFP_EXC_FLAGS_EN
  , output logic      o_ovf
  , output logic      o_inexact
`endif
);

  logic                   w_fp32;
  logic [31:0]            w_norm;
  logic                   w_zero;
  logic [5:0]             w_e;
  logic                   w_g32, w_r32, w_s32, w_up32;
  logic [FP32_MANT_W:0]   w_m32;
  logic [FP32_EXP_W-1:0]  w_exp32;
  logic                   w_g16, w_r16, w_s16, w_up16;
  logic [FP16_MANT_W:0]   w_m16;
  logic [5:0]             w_exp16;
  logic                   w_ovf16;
  logic [15:0]            w_res16;

  assign w_fp32 = i_fp32 & HAS_FP32;
  assign w_norm = i_lane.mag << i_lane.lzc;
  assign w_zero = ~w_norm[31];
  assign w_e    = 6'd31 - i_lane.lzc;

  assign w_g32   = w_norm[7];
  assign w_r32   = w_norm[6];
  assign w_s32   = |w_norm[5:0];
  assign w_up32  = w_g32 & (w_r32 | w_s32 | w_norm[8]);
  assign w_m32   = {1'b0, w_norm[30:8]} + 24'(w_up32);
  assign w_exp32 = 8'(w_e) + 8'(FP32_BIAS) + 8'(w_m32[FP32_MANT_W]);

  assign w_g16   = w_norm[20];
  assign w_r16   = w_norm[19];
  assign w_s16   = |w_norm[18:0];
  assign w_up16  = w_g16 & (w_r16 | w_s16 | w_norm[21]);
  assign w_m16   = {1'b0, w_norm[30:21]} + 11'(w_up16);
  assign w_exp16 = w_e + 6'(FP16_BIAS) + 6'(w_m16[FP16_MANT_W]);
  // Biased exponent 31 is the Inf encoding, so anything reaching it saturates.
  assign w_ovf16 = (w_exp16 >= 6'd31);
  assign w_res16 = w_ovf16 ? (i_lane.sign ? FP16_NEG_INF : FP16_POS_INF)
                           : {i_lane.sign, w_exp16[FP16_EXP_W-1:0], w_m16[FP16_MANT_W-1:0]};

  assign o_res = w_zero ? 32'd0
               : w_fp32 ? {i_lane.sign, w_exp32, w_m32[FP32_MANT_W-1:0]}
               : {16'd0, w_res16};

`ifdef INTTOFP_EXC_FLAGS_EN
  assign o_ovf     = ~w_zero & ~w_fp32 & w_ovf16;
  assign o_inexact = ~w_zero & (w_fp32 ? (w_g32 | w_r32 | w_s32)
                                       : (w_g16 | w_r16 | w_s16 | w_ovf16));
`endif

endmodule

// File: rtl/intto_fp.sv
// Two-stage pipelined INT32/INT16 to FP32/FP16 converter with valid/ready handshake.
// Define INTTOFP_EXC_FLAGS_EN to add the exc_flags {overflow, inexact} output.
module intto_fp
  import intto_fp_pkg::*;
#(
  parameter bit ZERO_IDLE_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_vld,
  output logic        inst_rdy,
  input  logic        src_prec,
  input  logic        dst_prec,
  input  logic        src_pos,
  input  logic        dst_pos,
  input  logic [31:0] in_reg,
  output logic [31:0] out_reg,
  output logic        result_vld,
  input  logic        result_rdy
`ifdef INTTOFP_EXC_FLAGS_EN
  , output logic [1:0] exc_flags
`endif
);

  logic        w_en;
  logic        w_accept;
  mode_e       w_mode;
  logic [31:0] w_x0, w_x1;
  logic        w_s1_fp32;
  logic [31:0] w_l0_res, w_l1_res;
  logic [31:0] w_s2_out;

  logic        r_s1_vld;
  mode_e       r_s1_mode;
  logic        r_s1_dst_pos;
  lane_s1_t    r_s1_lane0, r_s1_lane1;
  logic        r_s2_vld;
  logic [31:0] r_out;

  assign w_en     = ~r_s2_vld | result_rdy;
  assign w_accept = inst_vld & w_en;
  assign w_mode   = mode_e'({src_prec, dst_prec});
  assign w_x1     = {{16{in_reg[31]}}, in_reg[31:16]};

  always_comb begin
    w_x0 = in_reg;
    case (w_mode)
      MODE_I16_F32: w_x0 = src_pos ? w_x1 : {{16{in_reg[15]}}, in_reg[15:0]};
      MODE_I16_F16: w_x0 = {{16{in_reg[15]}}, in_reg[15:0]};
      default:      w_x0 = in_reg;
    endcase
  end

  assign w_s1_fp32 = (r_s1_mode == MODE_I32_F32) || (r_s1_mode == MODE_I16_F32);

`ifdef INTTOFP_EXC_FLAGS_EN
  logic       w_l0_ovf, w_l0_inx, w_l1_ovf, w_l1_inx;
  logic       w_dual;
  logic [1:0] r_flags;
  assign w_dual = (r_s1_mode == MODE_I16_F16);
`endif

  intto_fp_lane #(.HAS_FP32(1'b1)) u_lane0 (
    .i_lane    (r_s1_lane0),
    .i_fp32    (w_s1_fp32),
    .o_res     (w_l0_res)
`ifdef INTTOFP_EXC_FLAGS_EN
    , .o_ovf     (w_l0_ovf)
    , .o_inexact (w_l0_inx)
`endif
  );

  intto_fp_lane #(.HAS_FP32(1'b0)) u_lane1 (
    .i_lane    (r_s1_lane1),
    .i_fp32    (1'b0),
    .o_res     (w_l1_res)
`ifdef INTTOFP_EXC_FLAGS_EN
    , .o_ovf     (w_l1_ovf)
    , .o_inexact (w_l1_inx)
`endif
  );

  // FP16 lane results arrive in the low half; place them in the selected half.
  always_comb begin
    w_s2_out = w_l0_res;
    case (r_s1_mode)
      MODE_I16_F16: w_s2_out = (w_l1_res << 16) | w_l0_res;
      MODE_I32_F16: w_s2_out = r_s1_dst_pos ? (w_l0_res << 16) : w_l0_res;
      default:      w_s2_out = w_l0_res;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld     <= 1'b0;
      r_s1_mode    <= MODE_I16_F16;
      r_s1_dst_pos <= 1'b0;
      r_s1_lane0   <= '0;
      r_s1_lane1   <= '0;
      r_s2_vld     <= 1'b0;
      r_out        <= '0;
`ifdef INTTOFP_EXC_FLAGS_EN
      r_flags      <= '0;
`endif
    end else if (w_en) begin
      r_s1_vld <= inst_vld;
      if (w_accept) begin
        r_s1_mode    <= w_mode;
        r_s1_dst_pos <= dst_pos;
        r_s1_lane0   <= lane_prep(w_x0);
        r_s1_lane1   <= lane_prep(w_x1);
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out <= w_s2_out;
`ifdef INTTOFP_EXC_FLAGS_EN
        r_flags <= {w_l0_ovf | (w_dual & w_l1_ovf), w_l0_inx | (w_dual & w_l1_inx)};
`endif
      end
    end
  end

  assign inst_rdy   = w_en;
  assign result_vld = r_s2_vld;
  assign out_reg    = (ZERO_IDLE_OUT && !r_s2_vld) ? 32'd0 : r_out;
`ifdef INTTOFP_EXC_FLAGS_EN
  assign exc_flags  = r_s2_vld ? r_flags : 2'b00;
`endif

endmodule

// File: tb/tb_intto_fp.sv
// Directed self-checking bench for intto_fp (hand-computed expected values).
// Exception flags are checked too when INTTOFP_EXC_FLAGS_EN is defined.
module tb_intto_fp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_vld = 1'b0;
  logic        inst_rdy;
  logic        src_prec = 1'b0;
  logic        dst_prec = 1'b0;
  logic        src_pos = 1'b0;
  logic        dst_pos = 1'b0;
  logic [31:0] in_reg = '0;
  logic [31:0] out_reg;
  logic        result_vld;
  logic        result_rdy = 1'b1;
`ifdef INTTOFP_EXC_FLAGS_EN
  logic [1:0]  exc_flags;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  intto_fp u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_vld   (inst_vld),
    .inst_rdy   (inst_rdy),
    .src_prec   (src_prec),
    .dst_prec   (dst_prec),
    .src_pos    (src_pos),
    .dst_pos    (dst_pos),
    .in_reg     (in_reg),
    .out_reg    (out_reg),
    .result_vld (result_vld),
    .result_rdy (result_rdy)
`ifdef INTTOFP_EXC_FLAGS_EN
    , .exc_flags (exc_flags)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One isolated operation: accept, latency, result, then idle output.
  task automatic do_op(input string tag, input logic sp, input logic dp, input logic spos,
                       input logic dpos, input logic [31:0] val, input logic [31:0] expv,
                       input logic [1:0] expf);
    @(negedge clk);
    inst_vld = 1'b1; src_prec = sp; dst_prec = dp; src_pos = spos; dst_pos = dpos;
    in_reg = val; result_rdy = 1'b1;
    #1 chk({tag, "_rdy"}, 32'(inst_rdy), 32'd1);
    @(negedge clk);
    inst_vld = 1'b0;
    in_reg   = 32'hDEAD_BEEF;
    chk({tag, "_lat1"}, 32'(result_vld), 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(result_vld), 32'd1);
    chk(tag, out_reg, expv);
`ifdef INTTOFP_EXC_FLAGS_EN
    chk({tag, "_flags"}, 32'(exc_flags), 32'(expf));
`else
    if (expf > 2'd3) $display("unreachable");
`endif
    @(negedge clk);
    chk({tag, "_idle_vld"}, 32'(result_vld), 32'd0);
    chk({tag, "_idle_out"}, out_reg, 32'd0);
  endtask

  logic [31:0] stream_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                   32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  initial begin
    int          iss;
    int          rd;
    logic [31:0] held;

    #12;
    chk("rst_vld", 32'(result_vld), 32'd0);
    chk("rst_out", out_reg, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_inst_rdy", 32'(inst_rdy), 32'd1);

    do_op("i32f32_one",   1, 1, 0, 0, 32'h00000001, 32'h3F800000, 2'b00);
    do_op("i32f32_m1",    1, 1, 0, 0, 32'hFFFFFFFF, 32'hBF800000, 2'b00);
    do_op("i32f32_min",   1, 1, 0, 0, 32'h80000000, 32'hCF000000, 2'b00);
    do_op("i32f32_zero",  1, 1, 0, 0, 32'h00000000, 32'h00000000, 2'b00);
    do_op("rne_tie_even", 1, 1, 0, 0, 32'h01000001, 32'h4B800000, 2'b01);
    do_op("rne_tie_up",   1, 1, 0, 0, 32'h01000003, 32'h4B800002, 2'b01);
    do_op("rne_carry",    1, 1, 0, 0, 32'h7FFFFFFF, 32'h4F000000, 2'b01);
    do_op("dual_small",   0, 0, 0, 0, 32'h00020001, 32'h40003C00, 2'b00);
    do_op("dual_mixed",   0, 0, 0, 0, 32'hFFFB7FFF, 32'hC5007800, 2'b01);
    do_op("dual_rne",     0, 0, 0, 0, 32'h08030801, 32'h68026800, 2'b01);
    do_op("i16f32_hi",    0, 1, 1, 0, 32'hFFFF0000, 32'hBF800000, 2'b00);
    do_op("i16f32_lo",    0, 1, 0, 0, 32'h0005FFFE, 32'hC0000000, 2'b00);
    do_op("i32f16_inf",   1, 0, 0, 1, 32'd100000,   32'h7C000000, 2'b11);
    do_op("i32f16_m2",    1, 0, 0, 0, 32'hFFFFFFFE, 32'h0000C000, 2'b00);
    do_op("i32f16_max",   1, 0, 0, 0, 32'd65519,    32'h00007BFF, 2'b01);
    do_op("i32f16_65520", 1, 0, 0, 1, 32'd65520,    32'h7C000000, 2'b11);
    do_op("i32f16_ninf",  1, 0, 0, 0, 32'hFFFF0010, 32'h0000FC00, 2'b11);

    // Back-to-back stream with downstream stalled in cycles 3..5.
    iss = 0; rd = 0; held = '0;
    for (int c = 0; c < 40 && rd < 8; c++) begin
      @(negedge clk);
      result_rdy = !(c >= 3 && c <= 5);
      inst_vld   = (iss < 8);
      src_prec = 1'b1; dst_prec = 1'b1; src_pos = 1'b0; dst_pos = 1'b0;
      in_reg     = 32'(iss + 1);
      #1;
      if (c == 3) begin
        held = out_reg;
        chk("stall_rdy", 32'(inst_rdy), 32'd0);
      end
      if (c == 4 || c == 5) begin
        chk("stall_vld", 32'(result_vld), 32'd1);
        chk("stall_hold", out_reg, held);
        chk("stall_rdy", 32'(inst_rdy), 32'd0);
      end
      if (result_vld && result_rdy) begin
        chk("stream_data", out_reg, stream_exp[rd]);
        rd++;
      end
      if (inst_vld && inst_rdy) iss++;
    end
    chk("stream_count", 32'(rd), 32'd8);
    @(negedge clk);
    inst_vld = 1'b0;
    result_rdy = 1'b1;
    #1 chk("stream_no_dup", 32'(result_vld), 32'd0);
    @(negedge clk);

    // Reset pulsed while results are in flight.
    @(negedge clk);
    inst_vld = 1'b1; src_prec = 1'b1; dst_prec = 1'b1; in_reg = 32'd1;
    @(negedge clk);
    in_reg = 32'd2;
    @(negedge clk);
    in_reg = 32'd3;
    #1;
    chk("pre_rst_vld", 32'(result_vld), 32'd1);
    chk("pre_rst_out", out_reg, 32'h3F800000);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", 32'(result_vld), 32'd0);
    chk("async_rst_out", out_reg, 32'd0);
    inst_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_empty", 32'(result_vld), 32'd0);
    end
    do_op("post_rst_op", 1, 1, 0, 0, 32'd5, 32'h40A00000, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
